// File: rtl/stage_fetch.sv
// stage_fetch: instruction fetch stage pairing in-order imem responses with PCs in a slot buffer
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PW-1:0]    head, tail, fill;
  logic [CW-1:0]    alloc_cnt, pend_cnt, drop_cnt;
  logic [OW-1:0]    occupancy;
  logic             req_fire, out_fire, resp_drop, resp_fill, resp_any;

  // Handshakes, issue throttle (drops still hold a slot's worth of memory credit) and response routing
  always_comb begin
    out_valid      = (alloc_cnt != '0) && slot_filled[head];
    out_pc         = out_valid ? slot_pc[head] : '0;
    out_instr      = out_valid ? slot_instr[head] : '0;
    out_fire       = out_valid && out_ready;
    occupancy      = OW'(alloc_cnt) + OW'(drop_cnt) - OW'(out_fire);
    imem_req_valid = rst_n && !redirect && (occupancy < OW'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_drop      = imem_resp_valid && (drop_cnt != '0);
    resp_fill      = imem_resp_valid && (drop_cnt == '0) && (pend_cnt != '0);
    resp_any       = imem_resp_valid && ((drop_cnt != '0) || (pend_cnt != '0));
  end

  // Slot storage: allocate at tail with the fetch PC, fill the oldest unfilled slot
  always_ff @(posedge clk) begin
    if (req_fire) begin
      slot_pc[tail]     <= fetch_pc;
      slot_filled[tail] <= 1'b0;
    end
    if (resp_fill && !redirect) begin
      slot_instr[fill]  <= imem_resp_data;
      slot_filled[fill] <= 1'b1;
    end
  end

  // Pointers and counters; a redirect empties the buffer and turns unfilled slots into drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc & ~32'h3;
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_cnt + pend_cnt - CW'(resp_any);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= tail + PW'(1);
      end
      if (resp_fill) fill <= fill + PW'(1);
      if (out_fire) head <= head + PW'(1);
      alloc_cnt <= alloc_cnt + CW'(req_fire) - CW'(out_fire);
      pend_cnt  <= pend_cnt + CW'(req_fire) - CW'(resp_fill);
      drop_cnt  <= drop_cnt - CW'(resp_drop);
    end
  end
endmodule

// File: tb/tb_stage_fetch.sv
// tb_stage_fetch: scoreboard bench for stage_fetch with a latency-modelled instruction memory
`timescale 1ns/1ps
module tb_stage_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          req_cnt = 0;
  int          first_req = -1;
  int          first_out = -1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          snap;
  int          n;
  logic [31:0] last_pc = '0;
  logic [31:0] last_instr = '0;
  logic [31:0] exp_pc = RESET_PC;
  logic [63:0] sb [$];
  mreq_t       mq [$];
  logic        stall_prev = 1'b0;
  logic        redir_prev = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  stage_fetch #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [29:0] idx);
    return {2'b00, idx} * 32'h9E37_79B9 + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: in-order responses, drive at negedge, capture handshakes at negedge+3
  always @(negedge clk) begin
    if (rst_n && mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr[31:2]);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
    #3;
    if (!rst_n) begin
      mq.delete();
      imem_resp_valid = 1'b0;
    end else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    end
  end

  // Monitor/scoreboard: accepted requests push expected outputs, output handshakes pop and compare
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      sb.delete();
      exp_pc     = RESET_PC;
      stall_prev = 1'b0;
      redir_prev = 1'b0;
    end else begin
      if (redir_prev) chk("flush_out_valid", 32'(out_valid), 32'd0);
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc", out_pc, hold_pc);
        chk("hold_instr", out_instr, hold_instr);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("out_pc", out_pc, sb[0][63:32]);
          chk("out_instr", out_instr, sb[0][31:0]);
          void'(sb.pop_front());
        end
        if (first_out < 0) first_out = cyc;
        out_cnt++;
        last_pc    = out_pc;
        last_instr = out_instr;
      end
      if (redirect) begin
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        sb.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        sb.push_back({exp_pc, mem_word(exp_pc[31:2])});
        exp_pc = exp_pc + 32'd4;
        if (first_req < 0) first_req = cyc;
        req_cnt++;
      end
      stall_prev = out_valid && !out_ready && !redirect;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      redir_prev = redirect;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    first_req = -1;
    first_out = -1;
    out_cnt   = 0;
    req_cnt   = 0;
  endtask

  initial begin
    // Streaming start-up with 1-cycle memory
    do_reset();
    repeat (11) @(negedge clk);
    #4;
    chk("startup_lag", 32'(first_out - first_req), 32'd2);
    chk("startup_outs", 32'(out_cnt), 32'd10);
    chk("startup_last_pc", last_pc, 32'h24);

    // Decode stalled: buffer fills to DEPTH then drains in order
    out_ready = 1'b0;
    do_reset();
    repeat (9) @(negedge clk);
    #4;
    chk("full_req_cnt", 32'(req_cnt), 32'd4);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_out_pc", out_pc, 32'h0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("drain_cnt", 32'(out_cnt), 32'd4);
    chk("drain_last_pc", last_pc, 32'hC);

    // 3-cycle memory, redirect with three fetches outstanding
    lat_min = 3;
    lat_max = 3;
    do_reset();
    repeat (3) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    @(negedge clk);
    redirect = 1'b0;
    n = 0;
    while (out_cnt == 0 && n < 40) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("redir_got_output", 32'(out_cnt != 0), 32'd1);
    chk("redir_first_pc", last_pc, 32'h1000);
    chk("redir_first_instr", last_instr, mem_word(30'h400));

    // Redirects colliding with a response and an output handshake, then back-to-back
    lat_min = 1;
    lat_max = 1;
    do_reset();
    repeat (5) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    @(negedge clk);
    redirect_pc = 32'h0000_3000;
    @(negedge clk);
    redirect_pc = 32'h0000_4006;
    @(negedge clk);
    redirect = 1'b0;
    #4 snap = out_cnt;
    repeat (9) @(negedge clk);
    #4;
    chk("b2b_outs", 32'(out_cnt - snap), 32'd8);
    chk("b2b_last_pc", last_pc, 32'h4020);

    // Address wrap, then reset mid-stream with fetches outstanding
    lat_min = 3;
    lat_max = 3;
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    repeat (7) @(negedge clk);
    #4;
    chk("wrap_last_pc", last_pc, 32'h4);
    do_reset();
    repeat (6) @(negedge clk);
    #4;
    chk("rst_restart_outs", 32'(out_cnt), 32'd3);
    chk("rst_restart_pc", last_pc, RESET_PC + 32'h8);

    // Random ready, latency and redirects
    lat_min = 1;
    lat_max = 5;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      imem_req_ready = 1'($urandom_range(1, 0));
      out_ready      = $urandom_range(3, 0) != 0;
      redirect       = $urandom_range(99, 0) < 3;
      redirect_pc    = $urandom;
    end
    @(negedge clk);
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    snap = out_cnt;
    repeat (30) @(negedge clk);
    #4;
    chk("rand_progress", 32'(out_cnt > snap), 32'd1);
    chk("rand_min_outs", 32'(out_cnt > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
Instruction fetch stage, directly upstream of the decode stage. Holds the fetch PC and issues word fetches to instruction memory over a valid/ready request channel. Pairs in-order responses with their PCs in a small slot buffer and presents {pc, instr} to decode via valid/ready. Taken branches and jumps from downstream redirect it; in-flight fetches are flushed, and stale responses are discarded.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
DEPTH, 4, slot-buffer entries and max outstanding fetches; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response valid; in order, >= 1 cycle after request handshake, no backpressure
imem_resp_data  input  32  fetched instruction word
out_valid  output  1  {out_pc, out_instr} valid to decode
out_ready  input  1  decode accepts
out_pc  output  32  PC of presented instruction
out_instr  output  32  presented instruction

Behaviour:
- Reset (asynchronous, active-low rst_n):
  - fetch_pc = RESET_PC; slot buffer empty; drop_cnt = 0.
  - imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0.
  - First request may issue in the first clk edge cycle after rst_n rises.
- Slot buffer: DEPTH-entry circular queue with head/tail pointers (wrap modulo DEPTH).
  - Each slot holds {pc, instr, filled}.
  - Allocated at the tail on a request handshake, storing pc = fetch_pc.
  - Filled at the oldest unfilled slot on a non-dropped response.
  - Freed at the head on an output handshake.
- Request issue:
  - imem_req_valid = !redirect && (alloc_cnt - out_fire + drop_cnt < DEPTH).
  - out_fire = out_valid && out_ready; a same-cycle drain frees a slot (combinational path out_ready -> imem_req_valid is intended).
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (32-bit wrap from 32'hFFFF_FFFC to 0); slot allocated.
  - Request may be retracted before handshake; memory samples only on handshake.
- Output:
  - out_valid = head slot allocated and filled; out_pc/out_instr from head slot.
  - Stable while out_valid && !out_ready.
  - With 1-cycle memory latency and out_ready held high, sustains 1 instruction/cycle after a 2-cycle start-up.
- Response:
  - If drop_cnt > 0: discard, drop_cnt -= 1.
  - Else: fill oldest unfilled slot.
  - A response with nothing outstanding is a protocol error; ignore it (bench asserts).
- Redirect (takes priority over everything except reset):
  - No request issued that cycle.
  - Next cycle: fetch_pc = {redirect_pc[31:2], 2'b00}; all slots freed; out_valid = 0.
  - Next-cycle drop_cnt = drop_cnt + (allocated unfilled slots) − (response arriving this cycle ? 1 : 0).
  - A response arriving in the redirect cycle is discarded.
  - An out handshake in the redirect cycle counts as consumed; no further effect.
  - Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Full: alloc_cnt + drop_cnt == DEPTH with no drain -> imem_req_valid = 0.
- Empty: no filled head -> out_valid = 0.
- drop_cnt width: clog2(DEPTH)+1; never exceeds DEPTH.

Test Plan:
- Reset release, 1-cycle memory, out_ready=1 -> requests at 0x0,0x4,0x8…; outputs (0x0,mem[0]),(0x4,mem[1]) in order; from the 3rd cycle on, one output per cycle.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid=0; out_pc held at 0x0; on release, 0x0..0xC drain in order, fetching resumes at 0x10.
- 3-cycle memory latency, redirect to 0x1003 with 3 fetches outstanding -> next request addr 0x1000; 3 stale responses discarded; first output (0x1000, mem[0x400]).
- Redirect in the same cycle as a response and an out handshake -> the response is dropped, drop_cnt correct; no stale instruction ever reaches out_valid.
- imem_req_ready toggling randomly, random latency 1–5, random out_ready, 1000 cycles -> output PC sequence strictly +4 between redirects; every out_instr == mem[out_pc>>2].
- rst_n asserted mid-stream with outstanding fetches -> outputs zero immediately; after release, fetch restarts at RESET_PC with an empty buffer (bench memory also reset).
